// File: rtl/ptp_forward_delay_sched.sv
// ptp_forward_delay_sched: round-robin sharing of one forward-delay unit among PORT_NUM ports
module ptp_forward_delay_sched #(
  parameter int PORT_NUM    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [PORT_NUM*32-1:0] i_req_t4,
  input  logic [PORT_NUM*32-1:0] i_req_t5,
  input  logic [PORT_NUM-1:0]   i_req_valid,
  output logic [PORT_NUM-1:0]   o_req_ready,
  output logic [31:0]           o_sync_in_t4,
  output logic [31:0]           o_sync_out_t5,
  output logic                  o_forwardtime_valid,
  input  logic [31:0]           i_forward_time,
  input  logic                  i_forward_time_valid,
  output logic [31:0]           o_port_forward_time,
  output logic [PORT_NUM-1:0]   o_port_forward_time_valid,
  output logic                  o_timeout_err,
  output logic [3:0]            o_timeout_port
);
  localparam int IW = PORT_NUM > 1 ? $clog2(PORT_NUM) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nxt;
  logic [PORT_NUM-1:0] pending, rot;
  logic [31:0] t4_buf [PORT_NUM];
  logic [31:0] t5_buf [PORT_NUM];
  logic [IW-1:0] rr_ptr, grant, sel, off;
  logic [IW:0] sum;
  logic [15:0] cnt;
  logic done, expire, issue;
  assign o_req_ready = ~pending;
  assign issue = state == IDLE && |pending;
  assign done = state == WAIT && i_forward_time_valid;
  assign expire = state == WAIT && !i_forward_time_valid && cnt == 16'(TIMEOUT_CYC - 1);
  // rotate pending so rr_ptr sits at bit 0, then take the lowest set bit
  always_comb begin
    rot = PORT_NUM'({pending, pending} >> rr_ptr);
    off = '0;
    for (int i = PORT_NUM - 1; i >= 0; i--) if (rot[i]) off = IW'(i);
    sum = {1'b0, rr_ptr} + {1'b0, off};
    sel = sum >= (IW+1)'(PORT_NUM) ? IW'(sum - (IW+1)'(PORT_NUM)) : sum[IW-1:0];
  end
  always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE ? (|pending ? ISSUE : IDLE) :
                state == ISSUE ? WAIT :
                state == WAIT && !(done || expire) ? WAIT : IDLE;
  always_ff @(posedge i_clk)
    for (int k = 0; k < PORT_NUM; k++)
      if (i_req_valid[k] && !pending[k]) begin
        t4_buf[k] <= i_req_t4[k*32 +: 32];
        t5_buf[k] <= i_req_t5[k*32 +: 32];
      end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending <= '0;
      rr_ptr <= '0;
      grant <= '0;
      cnt <= '0;
      o_sync_in_t4 <= '0;
      o_sync_out_t5 <= '0;
      o_forwardtime_valid <= 1'b0;
      o_port_forward_time <= '0;
      o_port_forward_time_valid <= '0;
      o_timeout_err <= 1'b0;
      o_timeout_port <= '0;
    end else begin
      o_forwardtime_valid <= issue;
      o_port_forward_time_valid <= '0;
      o_timeout_err <= 1'b0;
      cnt <= state == WAIT ? cnt + 16'd1 : '0;
      if (issue) begin
        grant <= sel;
        o_sync_in_t4 <= t4_buf[sel];
        o_sync_out_t5 <= t5_buf[sel];
      end
      if (done) begin
        o_port_forward_time <= i_forward_time;
        o_port_forward_time_valid <= PORT_NUM'(1) << grant;
      end
      if (expire) begin
        o_timeout_err <= 1'b1;
        o_timeout_port <= 4'(grant);
      end
      if (done || expire) rr_ptr <= grant == IW'(PORT_NUM - 1) ? '0 : grant + 1'b1;
      for (int k = 0; k < PORT_NUM; k++)
        if (i_req_valid[k] && !pending[k]) pending[k] <= 1'b1;
        else if ((done || expire) && grant == IW'(k)) pending[k] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ptp_forward_delay_sched.sv
// tb_ptp_forward_delay_sched: directed checks of arbitration, result routing, watchdog and reset
module tb_ptp_forward_delay_sched;
  logic clk = 0;
  logic rst;
  logic [127:0] req_t4, req_t5;
  logic [3:0] req_valid, req_ready, pft_valid;
  logic [31:0] sync_t4, sync_t5, ft, pft;
  logic fwd_valid, ft_valid, terr;
  logic [3:0] tport;
  int checks = 0, fails = 0;

  ptp_forward_delay_sched #(.PORT_NUM(4), .TIMEOUT_CYC(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_t4(req_t4), .i_req_t5(req_t5),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .o_sync_in_t4(sync_t4), .o_sync_out_t5(sync_t5), .o_forwardtime_valid(fwd_valid),
    .i_forward_time(ft), .i_forward_time_valid(ft_valid),
    .o_port_forward_time(pft), .o_port_forward_time_valid(pft_valid),
    .o_timeout_err(terr), .o_timeout_port(tport));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(output bit ok);
    ok = fwd_valid;
    for (int i = 0; i < 10 && !ok; i++) begin
      step;
      ok = fwd_valid;
    end
  endtask

  task automatic give_result(input logic [31:0] v);
    step;
    ft = v;
    ft_valid = 1;
    step;
    ft_valid = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    step;
    step;
    rst = 0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (req_ready !== 4'hF) begin fails++; $display("FAIL reset_ready got %h exp f", req_ready); end
    checks++; if (fwd_valid !== 1'b0) begin fails++; $display("FAIL reset_fwd_valid got %b exp 0", fwd_valid); end
    checks++; if (pft_valid !== 4'h0) begin fails++; $display("FAIL reset_pft_valid got %h exp 0", pft_valid); end
    checks++; if ({sync_t4, sync_t5, pft} !== 96'h0) begin fails++; $display("FAIL reset_data got %h %h %h exp 0", sync_t4, sync_t5, pft); end
    checks++; if ({terr, tport} !== 5'h0) begin fails++; $display("FAIL reset_timeout got %b %h exp 0 0", terr, tport); end
  endtask

  task automatic test_single;
    req_t4[64 +: 32] = 32'h100;
    req_t5[64 +: 32] = 32'h350;
    req_valid = 4'b0100;
    step;
    req_valid = 0;
    checks++; if (req_ready !== 4'b1011) begin fails++; $display("FAIL single_ready got %h exp b", req_ready); end
    checks++; if (fwd_valid !== 1'b0) begin fails++; $display("FAIL single_early_issue got %b exp 0", fwd_valid); end
    step;
    checks++; if (fwd_valid !== 1'b1) begin fails++; $display("FAIL single_issue got %b exp 1", fwd_valid); end
    checks++; if ({sync_t4, sync_t5} !== {32'h100, 32'h350}) begin fails++; $display("FAIL single_t4t5 got %h %h exp 100 350", sync_t4, sync_t5); end
    step;
    checks++; if (fwd_valid !== 1'b0) begin fails++; $display("FAIL single_issue_pulse got %b exp 0", fwd_valid); end
    step;
    step;
    ft = 32'h250;
    ft_valid = 1;
    step;
    ft_valid = 0;
    checks++; if (pft !== 32'h250) begin fails++; $display("FAIL single_result got %h exp 250", pft); end
    checks++; if (pft_valid !== 4'b0100) begin fails++; $display("FAIL single_onehot got %h exp 4", pft_valid); end
    checks++; if (req_ready !== 4'hF) begin fails++; $display("FAIL single_ready_back got %h exp f", req_ready); end
    step;
    checks++; if (pft_valid !== 4'h0) begin fails++; $display("FAIL single_result_pulse got %h exp 0", pft_valid); end
  endtask

  task automatic test_all_ports;
    bit ok;
    logic [3:0] order [6] = '{0, 1, 2, 3, 0, 1};
    do_reset;
    for (int k = 0; k < 4; k++) begin
      req_t4[k*32 +: 32] = 32'h1000 + k;
      req_t5[k*32 +: 32] = 32'h2000 + k;
    end
    req_valid = 4'hF;
    step;
    req_valid = 0;
    checks++; if (req_ready !== 4'h0) begin fails++; $display("FAIL all_ready got %h exp 0", req_ready); end
    for (int n = 0; n < 6; n++) begin
      if (n == 4) begin
        req_t4[0 +: 32] = 32'h1100;
        req_t5[0 +: 32] = 32'h2100;
        req_t4[32 +: 32] = 32'h1101;
        req_t5[32 +: 32] = 32'h2101;
        req_valid = 4'b0011;
        step;
        req_valid = 0;
      end
      wait_issue(ok);
      checks++; if (!ok) begin fails++; $display("FAIL rr_issue_timeout n=%0d got none exp issue", n); end
      checks++; if (sync_t4 !== 32'h1000 + (n >= 4 ? 32'h100 : 0) + 32'(order[n])) begin fails++; $display("FAIL rr_order n=%0d got %h exp port %0d", n, sync_t4, order[n]); end
      give_result(32'hA0 + n);
      checks++; if (pft_valid !== 4'(1) << order[n]) begin fails++; $display("FAIL rr_route n=%0d got %h exp %h", n, pft_valid, 4'(1) << order[n]); end
      checks++; if (pft !== 32'hA0 + n) begin fails++; $display("FAIL rr_value n=%0d got %h exp %h", n, pft, 32'hA0 + n); end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    req_t4[32 +: 32] = 32'hFFFFFF00;
    req_t5[32 +: 32] = 32'h00000010;
    req_valid = 4'b0010;
    step;
    req_valid = 0;
    wait_issue(ok);
    checks++; if (!ok || {sync_t4, sync_t5} !== {32'hFFFFFF00, 32'h10}) begin fails++; $display("FAIL wrap_issue got %b %h %h exp 1 ffffff00 10", ok, sync_t4, sync_t5); end
    give_result(32'h110);
    checks++; if (pft !== 32'h110 || pft_valid !== 4'b0010) begin fails++; $display("FAIL wrap_result got %h %h exp 110 2", pft, pft_valid); end
  endtask

  task automatic test_timeout;
    bit ok;
    req_t4[96 +: 32] = 32'h33;
    req_t5[96 +: 32] = 32'h44;
    req_valid = 4'b1000;
    step;
    req_valid = 0;
    wait_issue(ok);
    checks++; if (!ok || sync_t4 !== 32'h33) begin fails++; $display("FAIL to_issue got %b %h exp 1 33", ok, sync_t4); end
    for (int i = 1; i <= 8; i++) begin
      step;
      checks++; if (terr !== 1'b0 || req_ready[3] !== 1'b0) begin fails++; $display("FAIL to_early i=%0d got err %b ready %b exp 0 0", i, terr, req_ready[3]); end
    end
    step;
    checks++; if (terr !== 1'b1) begin fails++; $display("FAIL to_pulse got %b exp 1", terr); end
    checks++; if (tport !== 4'd3) begin fails++; $display("FAIL to_port got %h exp 3", tport); end
    checks++; if (req_ready !== 4'hF || pft_valid !== 4'h0) begin fails++; $display("FAIL to_release got %h %h exp f 0", req_ready, pft_valid); end
    ft = 32'h777;
    ft_valid = 1;
    step;
    ft_valid = 0;
    checks++; if (terr !== 1'b0) begin fails++; $display("FAIL to_one_cycle got %b exp 0", terr); end
    step;
    checks++; if (pft_valid !== 4'h0 || pft !== 32'h110) begin fails++; $display("FAIL to_stray got %h %h exp 0 110", pft_valid, pft); end
    checks++; if (tport !== 4'd3 || fwd_valid !== 1'b0) begin fails++; $display("FAIL to_hold got %h %b exp 3 0", tport, fwd_valid); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    req_t4[0 +: 32] = 32'h10;
    req_t5[0 +: 32] = 32'h20;
    req_valid = 4'b0001;
    step;
    req_t4[0 +: 32] = 32'h99;
    req_t5[0 +: 32] = 32'h99;
    step;
    req_valid = 0;
    checks++; if (req_ready[0] !== 1'b0) begin fails++; $display("FAIL bp_ready got %b exp 0", req_ready[0]); end
    wait_issue(ok);
    checks++; if (!ok || {sync_t4, sync_t5} !== {32'h10, 32'h20}) begin fails++; $display("FAIL bp_pair got %b %h %h exp 1 10 20", ok, sync_t4, sync_t5); end
    give_result(32'hFFFFFFFF);
    checks++; if (pft !== 32'hFFFFFFFF || pft_valid !== 4'b0001) begin fails++; $display("FAIL bp_result got %h %h exp ffffffff 1", pft, pft_valid); end
    step;
    step;
    checks++; if (fwd_valid !== 1'b0 || req_ready !== 4'hF) begin fails++; $display("FAIL bp_no_second got %b %h exp 0 f", fwd_valid, req_ready); end
  endtask

  task automatic test_reset_wait;
    bit ok;
    bit seen = 0;
    req_t4[64 +: 32] = 32'h55;
    req_t5[64 +: 32] = 32'h66;
    req_valid = 4'b0100;
    step;
    req_valid = 0;
    wait_issue(ok);
    checks++; if (!ok) begin fails++; $display("FAIL rw_issue got none exp issue"); end
    step;
    step;
    rst = 1;
    step;
    checks++; if (req_ready !== 4'hF || fwd_valid !== 1'b0 || pft_valid !== 4'h0) begin fails++; $display("FAIL rw_ctrl got %h %b %h exp f 0 0", req_ready, fwd_valid, pft_valid); end
    checks++; if ({sync_t4, sync_t5, pft} !== 96'h0 || {terr, tport} !== 5'h0) begin fails++; $display("FAIL rw_data got %h %h %h %b %h exp 0", sync_t4, sync_t5, pft, terr, tport); end
    rst = 0;
    ft = 32'h123;
    ft_valid = 1;
    step;
    ft_valid = 0;
    for (int i = 0; i < 12; i++) begin
      step;
      if (pft_valid !== 4'h0 || fwd_valid !== 1'b0 || terr !== 1'b0) seen = 1;
    end
    checks++; if (seen) begin fails++; $display("FAIL rw_stray got activity exp none"); end
  endtask

  initial begin
    rst = 1;
    req_t4 = '0;
    req_t5 = '0;
    req_valid = 0;
    ft = 0;
    ft_valid = 0;
    test_reset;
    test_single;
    test_all_ports;
    test_wrap;
    test_timeout;
    test_back_to_back;
    test_reset_wait;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
